// File: rtl/vid_phy_controller_tx_datawidth_conv_if.sv
// Link-side bundle of the TX data-width converter: 40-bit link words in,
// 20-bit GT words and status flags out.
interface vid_phy_controller_tx_datawidth_conv_if;
  logic [39:0] LNK_DAT_IN;
  logic [19:0] TX_DAT_OUT;
  logic        TX_RUN_OUT;
  logic        UNFL_OUT;
  logic        OVFL_OUT;

  modport master (
    output LNK_DAT_IN,
    input  TX_DAT_OUT, TX_RUN_OUT, UNFL_OUT, OVFL_OUT
  );

  modport slave (
    input  LNK_DAT_IN,
    output TX_DAT_OUT, TX_RUN_OUT, UNFL_OUT, OVFL_OUT
  );
endinterface

// File: rtl/vid_phy_controller_tx_datawidth_conv.sv
// 40-bit LCLK_IN words to 20-bit TX_USRCLK_IN words through a gray-pointer
// dual-clock FIFO, with fill/run/underflow control on the read side.
module vid_phy_controller_tx_datawidth_conv #(
  parameter int FIFO_WRDS = 8,
  parameter int FILL_LVL  = 4,
  parameter int SYNC_FFS  = 2
) (
  input  logic TX_USRCLK_IN,
  input  logic LCLK_IN,
  input  logic rclk_rst,
  vid_phy_controller_tx_datawidth_conv_if.slave bus
);

  localparam int AW = $clog2(FIFO_WRDS);
  localparam int PW = AW + 1;
  localparam logic [AW:0] FILL_THR  = PW'(FILL_LVL);
  localparam logic [AW:0] FULL_MASK = PW'(3) << (AW - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [39:0] mem [FIFO_WRDS];

  // ---------------- LCLK_IN domain ----------------
  logic [SYNC_FFS-1:0] lrst_q;
  logic                l_rst;
  logic [AW:0]         wr_bin, wr_gray, wr_bin_nxt;
  logic [AW:0]         rd_sync [SYNC_FFS];
  logic                full, ovfl;

  // Reset asserts at once and releases only after SYNC_FFS link-clock edges.
  always_ff @(posedge LCLK_IN or posedge rclk_rst) begin
    if (rclk_rst) lrst_q <= '1;
    else          lrst_q <= lrst_q << 1;
  end
  assign l_rst = lrst_q[SYNC_FFS-1];

  always_ff @(posedge LCLK_IN or posedge l_rst) begin
    if (l_rst) begin
      for (int i = 0; i < SYNC_FFS; i++) rd_sync[i] <= '0;
    end else begin
      rd_sync[0] <= bin2gray(rd_bin);
      for (int i = 1; i < SYNC_FFS; i++) rd_sync[i] <= rd_sync[i-1];
    end
  end

  assign wr_bin_nxt = wr_bin + PW'(1);
  assign full       = (wr_gray == (rd_sync[SYNC_FFS-1] ^ FULL_MASK));

  always_ff @(posedge LCLK_IN or posedge l_rst) begin
    if (l_rst) begin
      wr_bin  <= '0;
      wr_gray <= '0;
      ovfl    <= 1'b0;
    end else if (full) begin
      ovfl    <= 1'b1;
    end else begin
      wr_bin  <= wr_bin_nxt;
      wr_gray <= bin2gray(wr_bin_nxt);
    end
  end

  // NOTE: storage has no reset; pointers alone define which entries are valid.
  always_ff @(posedge LCLK_IN) begin
    if (!full) mem[wr_bin[AW-1:0]] <= bus.LNK_DAT_IN;
  end

  // ---------------- TX_USRCLK_IN domain ----------------
  logic [AW:0] wr_sync [SYNC_FFS];
  logic [AW:0] wr_bin_s, rd_bin, rd_bin_nxt, occ;
  logic        empty, ph, hi_pend, unfl;
  logic        rd_en, unfl_set;
  logic [39:0] w;
  logic [19:0] dat;
  state_t      state, state_nxt;

  always_ff @(posedge TX_USRCLK_IN or posedge rclk_rst) begin
    if (rclk_rst) begin
      for (int i = 0; i < SYNC_FFS; i++) wr_sync[i] <= '0;
    end else begin
      wr_sync[0] <= wr_gray;
      for (int i = 1; i < SYNC_FFS; i++) wr_sync[i] <= wr_sync[i-1];
    end
  end

  assign wr_bin_s   = gray2bin(wr_sync[SYNC_FFS-1]);
  assign occ        = wr_bin_s - rd_bin;
  assign empty      = (wr_sync[SYNC_FFS-1] == bin2gray(rd_bin));
  assign rd_bin_nxt = rd_bin + PW'(1);

  always_ff @(posedge TX_USRCLK_IN or posedge rclk_rst) begin
    if (rclk_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    unfl_set  = 1'b0;
    case (state)
      IDLE: state_nxt = FILL;
      FILL: if (occ >= FILL_THR) state_nxt = RUN;
      RUN: begin
        if (!ph) begin
          if (empty) begin
            state_nxt = FILL;
            unfl_set  = 1'b1;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ph=0 fetches a word into w; the next edge emits its low half, the one
  // after that its high half while the following word is fetched.
  always_ff @(posedge TX_USRCLK_IN or posedge rclk_rst) begin
    if (rclk_rst) begin
      ph      <= 1'b0;
      rd_bin  <= '0;
      w       <= '0;
      hi_pend <= 1'b0;
      dat     <= '0;
      unfl    <= 1'b0;
    end else begin
      ph <= (state == RUN && state_nxt == RUN) ? ~ph : 1'b0;
      if (rd_en) begin
        w      <= mem[rd_bin[AW-1:0]];
        rd_bin <= rd_bin_nxt;
      end
      if (unfl_set) unfl <= 1'b1;
      if (state == RUN && ph) begin
        dat     <= w[19:0];
        hi_pend <= 1'b1;
      end else if (hi_pend) begin
        dat     <= w[39:20];
        hi_pend <= 1'b0;
      end else begin
        dat     <= '0;
      end
    end
  end

  assign bus.TX_DAT_OUT = dat;
  assign bus.TX_RUN_OUT = (state == RUN);
  assign bus.UNFL_OUT   = unfl;
  assign bus.OVFL_OUT   = ovfl;

endmodule

// File: tb/tb_vid_phy_controller_tx_datawidth_conv.sv
// Directed bench: startup latency, streaming, link-clock stall (underflow),
// user-clock stall (overflow) and mid-stream reset.
module tb_vid_phy_controller_tx_datawidth_conv;

  localparam int FILL_LVL = 4;
  localparam int LHALF    = 3332;   // LCLK_IN half period
  localparam int THALF    = 1666;   // TX_USRCLK_IN half period (2x link rate)

  logic tx_clk  = 1'b0;
  logic lclk    = 1'b0;
  logic rclk_rst;
  bit   tx_en   = 1'b1;
  bit   lclk_en = 1'b1;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cur_idx = 0;   // index of the word currently driven
  int pos_idx = 0;   // index presented at the latest LCLK_IN rising edge
  int exp_idx;
  bit exp_hi;
  int first_idx;
  int resume_idx;
  bit seen;

  vid_phy_controller_tx_datawidth_conv_if bus ();

  vid_phy_controller_tx_datawidth_conv #(
    .FIFO_WRDS(8), .FILL_LVL(FILL_LVL), .SYNC_FFS(2)
  ) dut (
    .TX_USRCLK_IN(tx_clk),
    .LCLK_IN     (lclk),
    .rclk_rst    (rclk_rst),
    .bus         (bus.slave)
  );

  initial forever begin
    #THALF;
    if (tx_en) tx_clk = ~tx_clk;
  end

  initial begin
    #700;
    forever begin
      #LHALF;
      if (lclk_en) lclk = ~lclk;
    end
  end

  // Incrementing link words: low half n, high half 20'h80000 + n.
  initial begin
    bus.LNK_DAT_IN = {20'h80000, 20'h00000};
    forever begin
      @(posedge lclk);
      pos_idx = cur_idx;
      @(negedge lclk);
      cur_idx++;
      bus.LNK_DAT_IN = {20'h80000 + 20'(cur_idx), 20'(cur_idx)};
    end
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_run(output bit found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge tx_clk);
      if (bus.TX_RUN_OUT === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Compares n consecutive output samples against the interleaved stream.
  task automatic check_stream(input string tag, input int n);
    logic [19:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge tx_clk);
      e = exp_hi ? (20'h80000 + 20'(exp_idx)) : 20'(exp_idx);
      check(tag, bus.TX_DAT_OUT, e);
      if (exp_hi) exp_idx++;
      exp_hi = ~exp_hi;
    end
  endtask

  initial begin
    rclk_rst = 1'b0;
    #10 rclk_rst = 1'b1;

    // Reset state
    repeat (5) @(negedge tx_clk);
    check("rst_dat",  bus.TX_DAT_OUT, 0);
    check("rst_run",  bus.TX_RUN_OUT, 0);
    check("rst_unfl", bus.UNFL_OUT,   0);
    check("rst_ovfl", bus.OVFL_OUT,   0);

    // Release: link reset lifts after two LCLK edges, third edge writes
    rclk_rst = 1'b0;
    repeat (3) @(posedge lclk);
    #1 first_idx = cur_idx;
    check("fill_dat", bus.TX_DAT_OUT, 0);
    check("fill_run", bus.TX_RUN_OUT, 0);

    wait_run(seen);
    check("run_seen", seen, 1);
    check("fill_lvl", (pos_idx - first_idx + 1) >= FILL_LVL, 1);
    @(negedge tx_clk);
    check("lat_gap", bus.TX_DAT_OUT, 0);
    exp_idx = first_idx;
    exp_hi  = 1'b0;
    check_stream("stream", 40);
    check("stream_unfl", bus.UNFL_OUT, 0);
    check("stream_ovfl", bus.OVFL_OUT, 0);

    // Link clock stall for 10 cycles -> underflow, back to FILL
    lclk_en = 1'b0;
    #(10 * 2 * LHALF);
    @(negedge tx_clk);
    check("unfl_flag", bus.UNFL_OUT,   1);
    check("unfl_run",  bus.TX_RUN_OUT, 0);
    check("unfl_dat",  bus.TX_DAT_OUT, 0);
    resume_idx = pos_idx + 1;
    lclk_en = 1'b1;
    wait_run(seen);
    check("resume_run", seen, 1);
    @(negedge tx_clk);
    check("resume_gap", bus.TX_DAT_OUT, 0);
    exp_idx = resume_idx;
    exp_hi  = 1'b0;
    check_stream("resume", 8);

    // User clock stall for 20 link cycles -> overflow, survivors in order
    tx_en = 1'b0;
    #(20 * 2 * LHALF + 100);
    check("ovfl_flag", bus.OVFL_OUT, 1);
    tx_en = 1'b1;
    check_stream("survivors", 16);
    check("ovfl_sticky", bus.OVFL_OUT, 1);
    check("unfl_sticky", bus.UNFL_OUT, 1);

    // Reset mid-RUN for 3 cycles
    #500 rclk_rst = 1'b1;
    #1;
    check("mid_rst_dat",  bus.TX_DAT_OUT, 0);
    check("mid_rst_run",  bus.TX_RUN_OUT, 0);
    check("mid_rst_unfl", bus.UNFL_OUT,   0);
    check("mid_rst_ovfl", bus.OVFL_OUT,   0);
    repeat (3) @(negedge tx_clk);
    rclk_rst = 1'b0;
    repeat (3) @(posedge lclk);
    #1 first_idx = cur_idx;
    wait_run(seen);
    check("rerun_seen", seen, 1);
    @(negedge tx_clk);
    check("rerun_gap", bus.TX_DAT_OUT, 0);
    exp_idx = first_idx;
    exp_hi  = 1'b0;
    check_stream("rerun", 8);
    check("rerun_unfl", bus.UNFL_OUT, 0);
    check("rerun_ovfl", bus.OVFL_OUT, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
